// File: rtl/irq_ctrl.sv
// irq_ctrl: interrupt controller sequencing the datapath's exception-context PC switch.
// Synchronizes and edge-detects external lines, keeps per-line pending/mask state,
// selects the lowest-index enabled request and steps IDLE->ENTRY->ACTIVE->RESUME.
// Ports:
//   clk, rst      : rising-edge clock, asynchronous active-high reset
//   irq_in        : asynchronous external interrupt lines (rising-edge triggered)
//   eret          : ISR-return pulse from the control unit
//   cfg_we/addr/wd: config write port (0 MASK, 1 PENDING W1C, 2 ID, 3 STATUS)
//   cfg_rd        : combinational config read data selected by cfg_addr
//   irq_entry     : one-cycle pulse, datapath saves PC and jumps to irq_addr
//   irq_resume    : one-cycle pulse, datapath restores the saved PC
//   irq_addr      : ISR vector, VEC_BASE + (irq_id << 4)
//   irq_id        : index of the interrupt being serviced
//   in_isr        : high whenever the FSM is not idle
module irq_ctrl #(
  parameter int unsigned N_IRQ    = 4,
  parameter logic [31:0] VEC_BASE = 32'h0000_0100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             eret,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [31:0]      cfg_wd,
  output logic [31:0]      cfg_rd,
  output logic             irq_entry,
  output logic             irq_resume,
  output logic [31:0]      irq_addr,
  output logic [3:0]       irq_id,
  output logic             in_isr
);

  localparam int unsigned ID_W = 4;

  localparam logic [1:0] ADDR_MASK    = 2'd0;
  localparam logic [1:0] ADDR_PENDING = 2'd1;
  localparam logic [1:0] ADDR_ID      = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENTRY  = 2'd1,
    ACTIVE = 2'd2,
    RESUME = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [N_IRQ-1:0]  s1_q, s2_q, s3_q;
  logic [N_IRQ-1:0]  pending_q, pending_d;
  logic [N_IRQ-1:0]  mask_q, mask_d;
  logic [ID_W-1:0]   irq_id_q, irq_id_d;

  logic [N_IRQ-1:0]  edge_c;
  logic [N_IRQ-1:0]  req_c;
  logic [ID_W-1:0]   sel_c;
  logic              take_c;
  logic [N_IRQ-1:0]  take_clr_c;
  logic [N_IRQ-1:0]  w1c_c;
  logic              mask_wr_c;

  // Upper write-data bits have no storage behind them.
  logic              cfg_wd_unused;
  assign cfg_wd_unused = ^cfg_wd[31:N_IRQ];

  // Two-flop synchronizer plus a delay flop for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= irq_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign edge_c = s2_q & ~s3_q;
  assign req_c  = pending_q & mask_q;

  // Lowest set index wins; scanning downward lets the last hit override.
  always_comb begin
    sel_c = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (req_c[i]) begin
        sel_c = ID_W'(i);
      end
    end
  end

  assign take_c     = (state_q == IDLE) && (req_c != '0);
  assign take_clr_c = take_c ? (N_IRQ'(1) << sel_c) : '0;
  assign w1c_c      = (cfg_we && (cfg_addr == ADDR_PENDING)) ? cfg_wd[N_IRQ-1:0] : '0;
  assign mask_wr_c  = cfg_we && (cfg_addr == ADDR_MASK);

  // New edges are OR-ed in last so a set beats any same-cycle clear.
  always_comb begin
    pending_d = (pending_q & ~w1c_c & ~take_clr_c) | edge_c;
    mask_d    = mask_wr_c ? cfg_wd[N_IRQ-1:0] : mask_q;
  end

  // Next state and the latched service id.
  always_comb begin
    state_d  = state_q;
    irq_id_d = irq_id_q;
    unique case (state_q)
      IDLE: begin
        if (take_c) begin
          state_d  = ENTRY;
          irq_id_d = sel_c;
        end
      end
      ENTRY:   state_d = ACTIVE;
      ACTIVE: begin
        if (eret) begin
          state_d = RESUME;
        end
      end
      RESUME:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      mask_q    <= '0;
      irq_id_q  <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      irq_id_q  <= irq_id_d;
    end
  end

  // Pulses decode straight from the state register, so they cannot glitch or overlap.
  assign irq_entry  = (state_q == ENTRY);
  assign irq_resume = (state_q == RESUME);
  assign in_isr     = (state_q != IDLE);
  assign irq_id     = irq_id_q;
  assign irq_addr   = VEC_BASE + (32'(irq_id_q) << 4);

  // Config read mux.
  always_comb begin
    cfg_rd = '0;
    unique case (cfg_addr)
      ADDR_MASK:    cfg_rd = 32'(mask_q);
      ADDR_PENDING: cfg_rd = 32'(pending_q);
      ADDR_ID:      cfg_rd = 32'(irq_id_q);
      ADDR_STATUS:  cfg_rd = {29'd0, state_q, in_isr};
      default:      cfg_rd = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  irq_in;
  logic        eret;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wd;
  logic [31:0] cfg_rd;
  logic        irq_entry;
  logic        irq_resume;
  logic [31:0] irq_addr;
  logic [3:0]  irq_id;
  logic        in_isr;

  int checks   = 0;
  int failures = 0;

  irq_ctrl #(.N_IRQ(4), .VEC_BASE(32'h0000_0100)) dut (
    .clk        (clk),
    .rst        (rst),
    .irq_in     (irq_in),
    .eret       (eret),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wd     (cfg_wd),
    .cfg_rd     (cfg_rd),
    .irq_entry  (irq_entry),
    .irq_resume (irq_resume),
    .irq_addr   (irq_addr),
    .irq_id     (irq_id),
    .in_isr     (in_isr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit past the next rising edge.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_wd   = d;
    step(1);
    cfg_we   = 1'b0;
    cfg_wd   = '0;
  endtask

  task automatic rd_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
    cfg_addr = a;
    #1;
    check(tag, cfg_rd, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit seen;
    rst = 1'b1; irq_in = '0; eret = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_wd = '0;
    #12;
    // Reset defaults
    check("rst_entry",  32'(irq_entry),  32'd0);
    check("rst_resume", 32'(irq_resume), 32'd0);
    check("rst_in_isr", 32'(in_isr),     32'd0);
    check("rst_addr",   irq_addr,        32'h100);
    check("rst_id",     32'(irq_id),     32'd0);
    rd_check("rst_status", 2'd3, 32'd0);
    rd_check("rst_mask",   2'd0, 32'd0);
    rd_check("rst_pend",   2'd1, 32'd0);
    @(negedge clk); rst = 1'b0;
    step(2);

    // Single interrupt on line 2
    cfg_write(2'd0, 32'h4);
    rd_check("s_mask", 2'd0, 32'h4);
    irq_in[2] = 1'b1;
    step(2);                          // E0, E1
    check("s_entry_e1", 32'(irq_entry), 32'd0);
    step(1);                          // E2: pending set
    rd_check("s_pend_e2", 2'd1, 32'h4);
    check("s_entry_e2", 32'(irq_entry), 32'd0);
    step(1);                          // E3: ENTRY
    check("s_entry_e3", 32'(irq_entry), 32'd1);
    check("s_addr",     irq_addr,       32'h120);
    check("s_id",       32'(irq_id),    32'd2);
    rd_check("s_pend_e3", 2'd1, 32'h0);
    rd_check("s_status_entry", 2'd3, 32'h3);
    step(1);                          // E4: ACTIVE
    check("s_entry_e4", 32'(irq_entry), 32'd0);
    rd_check("s_status_active", 2'd3, 32'h5);
    rd_check("s_id_reg", 2'd2, 32'd2);
    step(3);
    check("s_active_hold", 32'(in_isr), 32'd1);
    eret = 1'b1;
    step(1);                          // F: RESUME
    eret = 1'b0;
    check("s_resume", 32'(irq_resume), 32'd1);
    check("s_resume_noentry", 32'(irq_entry), 32'd0);
    rd_check("s_status_resume", 2'd3, 32'h7);
    step(1);
    check("s_resume_off", 32'(irq_resume), 32'd0);
    rd_check("s_status_idle", 2'd3, 32'h0);
    check("s_addr_hold", irq_addr, 32'h120);
    irq_in[2] = 1'b0;
    step(4);

    // Priority: lines 3 and 1 together
    cfg_write(2'd0, 32'hF);
    irq_in = 4'b1010;
    step(4);                          // E0..E3
    check("p_entry1", 32'(irq_entry), 32'd1);
    check("p_id1",    32'(irq_id),    32'd1);
    check("p_addr1",  irq_addr,       32'h110);
    rd_check("p_pend_left", 2'd1, 32'h8);
    step(1);
    eret = 1'b1;
    step(1);
    eret = 1'b0;
    check("p_resume1", 32'(irq_resume), 32'd1);
    step(1);
    check("p_idle_gap", 32'(in_isr),    32'd0);
    check("p_gap_entry", 32'(irq_entry), 32'd0);
    step(1);
    check("p_entry2", 32'(irq_entry), 32'd1);
    check("p_id2",    32'(irq_id),    32'd3);
    check("p_addr2",  irq_addr,       32'h130);
    step(1);
    eret = 1'b1;
    step(1);
    eret = 1'b0;
    step(1);
    rd_check("p_pend_empty", 2'd1, 32'h0);
    rd_check("p_status", 2'd3, 32'h0);
    irq_in = '0;
    step(4);

    // Masked line stays pending until enabled
    cfg_write(2'd0, 32'h0);
    irq_in[0] = 1'b1;
    step(3);
    rd_check("m_pend", 2'd1, 32'h1);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step(1);
      if (irq_entry || in_isr) seen = 1'b1;
    end
    check("m_no_entry", 32'(seen), 32'd0);
    cfg_write(2'd0, 32'h1);
    check("m_entry_not_yet", 32'(irq_entry), 32'd0);
    step(1);
    check("m_entry", 32'(irq_entry), 32'd1);
    check("m_addr",  irq_addr,       32'h100);
    step(1);
    eret = 1'b1;
    step(1);
    eret = 1'b0;
    step(1);
    irq_in = '0;
    step(4);

    // W1C colliding with a fresh edge; eret while idle
    cfg_write(2'd0, 32'h0);
    irq_in[0] = 1'b1;
    step(2);                          // edge[0] true now
    cfg_write(2'd1, 32'h1);
    rd_check("w_set_wins", 2'd1, 32'h1);
    cfg_write(2'd1, 32'h1);
    rd_check("w_cleared", 2'd1, 32'h0);
    eret = 1'b1;
    step(1);
    eret = 1'b0;
    check("w_spur_resume", 32'(irq_resume), 32'd0);
    rd_check("w_spur_status", 2'd3, 32'h0);
    step(1);
    check("w_spur_resume2", 32'(irq_resume), 32'd0);
    irq_in = '0;
    step(4);

    // Reset while ACTIVE
    cfg_write(2'd0, 32'h1);
    irq_in = 4'b0011;
    step(5);                          // E0..E3 then ACTIVE
    rd_check("r_status_active", 2'd3, 32'h5);
    rd_check("r_pend_before", 2'd1, 32'h2);
    #2;
    rst = 1'b1;
    #1;
    check("r_in_isr",  32'(in_isr),     32'd0);
    check("r_resume",  32'(irq_resume), 32'd0);
    rd_check("r_pend", 2'd1, 32'h0);
    rd_check("r_mask", 2'd0, 32'h0);
    rd_check("r_status", 2'd3, 32'h0);
    irq_in = '0;
    step(2);
    check("r_resume_held", 32'(irq_resume), 32'd0);
    @(negedge clk); rst = 1'b0;
    step(3);
    check("r_resume_after", 32'(irq_resume), 32'd0);
    rd_check("r_status_after", 2'd3, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
